prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Instruction prefetch queue between the bus interface and the pre-decoder that produces pre_decode_t.
- Fetches code words from PS:PC and buffers up to QUEUE_BYTES bytes.
- Presents the head bytes as a flat window, which the decoder retires by pre_size.
- Flushed and re-pointed on branches, calls, interrupts and PS loads.

Parameters:
- QUEUE_BYTES, 6: queue depth in bytes (V30 value; 4 for V20-style builds). Range 4..8.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  discard queue contents, restart fetch at flush_ps:flush_pc
- flush_ps  in  16  new code segment
- flush_pc  in  16  new offset
- fetch_req  out  1  word fetch request to the BIU
- fetch_addr  out  20  physical address, ({ps,4'b0}+fetch_pc) mod 2^20
- fetch_ack  in  1  BIU accepts the request; fetch_data is valid this cycle
- fetch_data  in  16  little-endian word at fetch_addr & ~1
- q_data  out  8*QUEUE_BYTES  byte i at bits [8i+7:8i]; byte 0 is the head
- q_count  out  4  number of valid bytes, 0..QUEUE_BYTES
- q_pc  out  16  offset of the head byte
- consume  in  1  decoder retires consume_size bytes this cycle
- consume_size  in  4  pre_size, 1..QUEUE_BYTES

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - q_count=0, q_data=0, q_pc=0, fetch_req=0.
  - ps=16'hFFFF, fetch_pc=0 (V30 reset vector FFFF0).
  - State is IDLE. Reset overrides flush and consume in the same cycle.
- States: IDLE, REQ, DISCARD.
  - IDLE→REQ when free space (QUEUE_BYTES-q_count) ≥ 2, or ≥ 1 if fetch_pc[0]=1. Free space is evaluated after this cycle's consume.
  - In REQ: fetch_req=1 and fetch_addr holds stable until fetch_ack. On ack, bytes are appended and the state returns to IDLE. Back-to-back requests are allowed.
- Append rule:
  - fetch_pc even: append low byte then high byte; fetch_pc += 2.
  - fetch_pc odd: append the high byte only; fetch_pc += 1.
  - fetch_pc wraps mod 2^16 within the segment; ps is unchanged.
- Consume:
  - Shift the queue down by consume_size.
  - q_pc += consume_size mod 2^16.
  - Vacated high bytes read as 0.
  - consume_size > q_count is illegal; the bench asserts on it. The RTL clamps q_count at 0.
- Consume and ack in the same cycle: apply consume first, then append at the new tail. The new q_count must be ≤ QUEUE_BYTES. The space check guarantees this.
- Flush:
  - Next cycle: q_count=0, q_pc=flush_pc, fetch_pc=flush_pc, ps=flush_ps.
  - Flush wins over consume and over an ack in the same cycle; the acked data is dropped.
- Flush while in REQ without ack:
  - The request cannot be withdrawn, so the state moves to DISCARD.
  - fetch_req stays 1 with the old fetch_addr until ack; the data is dropped.
  - The state then goes to IDLE, and fetching restarts at the new address.
  - A further flush in DISCARD only updates the restart address.
- No ack ever arrives while fetch_req=0.
- Latency: bytes acked in cycle N are visible on q_data/q_count in cycle N+1.

Optional Feature:
- Macro PREFETCH_BYPASS_EN.
  - When defined: q_data/q_count combinationally include bytes being acked this cycle (not in DISCARD, not on flush). The decoder may consume them in cycle N. The clock-edge register update is unchanged.
  - When undefined: the outputs are registered only, giving the 1-cycle latency above.

Decomposition:
- Add to package types:
  - typedef enum bit [1:0] {PF_IDLE, PF_REQ, PF_DISCARD} prefetch_state_e
  - const PREFETCH_RESET_PS = 16'hFFFF
- No sub-module. The shift/append datapath and FSM are implemented in one module.

Test Plan:
- Reset then idle decoder: fetches at 0xFFFF0, 0xFFFF2, 0xFFFF4 (acked next cycle) → q_count 2,4,6, then fetch_req=0 with the queue full. q_pc=0.
- Flush ps=0x1000, pc=0x0003: first fetch_addr 0x10003, single byte appended (q_count=1). Next fetch_addr 0x10004.
- Full queue (6 bytes), consume_size=3 in the same cycle as an ack of word 0xBBAA → q_count=5. Bytes 3,4 are 0xAA,0xBB. q_pc advances by 3.
- Flush with fetch_req pending and ack 4 cycles later: fetch_addr stays at the old value until ack, data is dropped, q_count stays 0. Next request is at the new address.
- fetch_pc=0xFFFE, ps=0x2000: fetch 0x2FFFE, then 0x20000 (segment wrap). q_pc wraps 0xFFFF→0x0000 on consume.
- PREFETCH_BYPASS_EN defined, empty queue, ack 0x3412 → same-cycle q_count=2, q_data[15:0]=0x3412. consume_size=2 that cycle → next-cycle q_count=0.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Physical address helper: 20-bit segment:offset translation with wrap.
package prefetch_queue_pkg;

    typedef enum bit [1:0] {
        PF_IDLE,
        PF_REQ,
        PF_DISCARD
    } prefetch_state_e;

    localparam logic [15:0] PREFETCH_RESET_PS = 16'hFFFF;
    localparam logic [15:0] PREFETCH_RESET_PC = 16'h0000;

    function automatic logic [19:0] pf_phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off};
    endfunction

endpackage

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code words at PS:PC, presents a flat head window.
// Optional PREFETCH_BYPASS_EN: the window also shows bytes being acked this cycle.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// PF_IDLE    | no bus request outstanding; waiting for room in the queue
// PF_REQ     | fetch_req high, fetch_addr held until fetch_ack; data appended
// PF_DISCARD | flushed while a request was pending; wait for its ack, drop data
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int QUEUE_BYTES = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [15:0]              flush_ps,
    input  logic [15:0]              flush_pc,
    output logic                     fetch_req,
    output logic [19:0]              fetch_addr,
    input  logic                     fetch_ack,
    input  logic [15:0]              fetch_data,
    output logic [8*QUEUE_BYTES-1:0] q_data,
    output logic [3:0]               q_count,
    output logic [15:0]              q_pc,
    input  logic                     consume,
    input  logic [3:0]               consume_size
);

    localparam int         WIDE = QUEUE_BYTES + 2;
    localparam logic [4:0] QB5  = 5'(QUEUE_BYTES);

    prefetch_state_e          state_q, state_d;
    logic [15:0]              ps_q, ps_d;
    logic [15:0]              fpc_q, fpc_d;
    logic [15:0]              qpc_q, qpc_d;
    logic [8*QUEUE_BYTES-1:0] data_q, data_d;
    logic [3:0]               count_q, count_d;
    logic [19:0]              req_addr_q, req_addr_d;

    logic                     ack_live;
    logic [1:0]               app_n;
    logic [7:0]               app_lo;
    logic [8*WIDE-1:0]        wide;
    logic [4:0]               avail;
    logic [4:0]               limit;
    logic [4:0]               cs_in;
    logic [4:0]               cs_eff;
    logic [8*QUEUE_BYTES-1:0] data_next;
    logic [4:0]               free_d;
    logic                     want_req;

    assign ack_live = fetch_ack && (state_q == PF_REQ);
    assign app_n    = !ack_live ? 2'd0 : (fpc_q[0] ? 2'd1 : 2'd2);
    assign app_lo   = fpc_q[0] ? fetch_data[15:8] : fetch_data[7:0];
    assign avail    = {1'b0, count_q} + {3'b000, app_n};
    assign cs_in    = {1'b0, consume_size};

    // Appending at the old tail and then shifting by a clamped size is the same
    // as consume-then-append whenever the consume is legal.
`ifdef PREFETCH_BYPASS_EN
    assign limit = avail;
`else
    assign limit = {1'b0, count_q};
`endif

    always_comb begin
        cs_eff = 5'd0;
        if (consume) begin
            cs_eff = (cs_in > limit) ? limit : cs_in;
        end
    end

    always_comb begin
        int idx;
        idx  = 0;
        wide = {16'h0000, data_q};
        for (int i = 0; i < WIDE; i++) begin
            if ((app_n != 2'd0) && (i == int'(count_q))) begin
                wide[8*i +: 8] = app_lo;
            end
            if ((app_n == 2'd2) && (i == int'(count_q) + 1)) begin
                wide[8*i +: 8] = fetch_data[15:8];
            end
        end
        data_next = '0;
        for (int j = 0; j < QUEUE_BYTES; j++) begin
            idx = j + int'(cs_eff);
            if (idx < WIDE) begin
                data_next[8*j +: 8] = wide[8*idx +: 8];
            end
        end
    end

    always_comb begin
        ps_d    = ps_q;
        fpc_d   = fpc_q + {14'h0000, app_n};
        qpc_d   = consume ? (qpc_q + {12'h000, consume_size}) : qpc_q;
        data_d  = data_next;
        count_d = 4'(avail - cs_eff);
        if (flush) begin
            ps_d    = flush_ps;
            fpc_d   = flush_pc;
            qpc_d   = flush_pc;
            data_d  = '0;
            count_d = 4'd0;
        end
    end

    // Room is judged on the post-update queue so a same-cycle consume counts.
    assign free_d   = QB5 - {1'b0, count_d};
    assign want_req = fpc_d[0] ? (free_d >= 5'd1) : (free_d >= 5'd2);

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        case (state_q)
            PF_IDLE: begin
                if (!flush && want_req) state_d = PF_REQ;
            end
            PF_REQ: begin
                if (flush) begin
                    state_d = fetch_ack ? PF_IDLE : PF_DISCARD;
                end else if (fetch_ack) begin
                    state_d = want_req ? PF_REQ : PF_IDLE;
                end
            end
            PF_DISCARD: begin
                if (fetch_ack) state_d = PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase
        if (state_d == PF_REQ) begin
            req_addr_d = pf_phys_addr(ps_d, fpc_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= PF_IDLE;
            ps_q       <= PREFETCH_RESET_PS;
            fpc_q      <= PREFETCH_RESET_PC;
            qpc_q      <= PREFETCH_RESET_PC;
            data_q     <= '0;
            count_q    <= 4'd0;
            req_addr_q <= 20'h00000;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            fpc_q      <= fpc_d;
            qpc_q      <= qpc_d;
            data_q     <= data_d;
            count_q    <= count_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign fetch_req  = (state_q != PF_IDLE);
    assign fetch_addr = req_addr_q;
    assign q_pc       = qpc_q;

`ifdef PREFETCH_BYPASS_EN
    assign q_data  = (ack_live && !flush) ? wide[8*QUEUE_BYTES-1:0] : data_q;
    assign q_count = (ack_live && !flush) ? avail[3:0] : count_q;
`else
    assign q_data  = data_q;
    assign q_count = count_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: scoreboard of expected queue bytes,
// directed scenarios followed by random consume/ack/flush traffic.
module tb_prefetch_queue;

    localparam int QB = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic [15:0]   flush_ps = 16'h0000;
    logic [15:0]   flush_pc = 16'h0000;
    logic          fetch_req;
    logic [19:0]   fetch_addr;
    logic          fetch_ack = 1'b0;
    logic [15:0]   fetch_data = 16'h0000;
    logic [8*QB-1:0] q_data;
    logic [3:0]    q_count;
    logic [15:0]   q_pc;
    logic          consume = 1'b0;
    logic [3:0]    consume_size = 4'd0;

    always #5 clk = ~clk;

    prefetch_queue #(.QUEUE_BYTES(QB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .flush_ps     (flush_ps),
        .flush_pc     (flush_pc),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .fetch_data   (fetch_data),
        .q_data       (q_data),
        .q_count      (q_count),
        .q_pc         (q_pc),
        .consume      (consume),
        .consume_size (consume_size)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model: expected queue bytes plus fetch/decode pointers
    logic [7:0]  m_bytes[$];
    logic [15:0] m_ps;
    logic [15:0] m_fpc;
    logic [15:0] m_qpc;
    bit          m_disc;
    logic [19:0] m_old;

    function automatic logic [19:0] m_addr();
        return ({m_ps, 4'b0000} + {4'b0000, m_fpc});
    endfunction

    function automatic logic [19:0] m_req_addr();
        return m_disc ? m_old : m_addr();
    endfunction

    function automatic logic [8*QB-1:0] exp_win();
        logic [8*QB-1:0] w;
        w = '0;
        for (int i = 0; i < m_bytes.size() && i < QB; i++) w[8*i +: 8] = m_bytes[i];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        fetch_ack    = 1'b0;
        fetch_data   = 16'h0000;
        consume      = 1'b0;
        consume_size = 4'd0;
        flush        = 1'b0;
        @(negedge clk);
    endtask

    // drive one cycle of stimulus and advance the model the same way
    task automatic do_step(input bit ack_en, input logic [15:0] data, input bit cons_en,
                           input logic [3:0] csize, input bit fl_en,
                           input logic [15:0] fps, input logic [15:0] fpc);
        fetch_ack    = ack_en;
        fetch_data   = ack_en ? data : 16'h0000;
        consume      = cons_en;
        consume_size = cons_en ? csize : 4'd0;
        flush        = fl_en;
        flush_ps     = fps;
        flush_pc     = fpc;
        if (fl_en) begin
            if (fetch_req && !ack_en) begin
                if (!m_disc) m_old = m_addr();
                m_disc = 1'b1;
            end else begin
                m_disc = 1'b0;
            end
            m_bytes.delete();
            m_ps  = fps;
            m_fpc = fpc;
            m_qpc = fpc;
        end else begin
            if (cons_en) begin
                assert (csize >= 4'd1 && int'(csize) <= m_bytes.size())
                    else $error("illegal consume_size %0d with %0d bytes", csize, m_bytes.size());
                for (int k = 0; k < int'(csize); k++) void'(m_bytes.pop_front());
                m_qpc = m_qpc + {12'h000, csize};
            end
            if (ack_en) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                end else if (m_fpc[0]) begin
                    m_bytes.push_back(data[15:8]);
                    m_fpc = m_fpc + 16'd1;
                end else begin
                    m_bytes.push_back(data[7:0]);
                    m_bytes.push_back(data[15:8]);
                    m_fpc = m_fpc + 16'd2;
                end
            end
        end
        tick();
    endtask

    task automatic idle_step();
        do_step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (fetch_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            idle_step();
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        flush        = 1'b1;
        flush_ps     = 16'h1234;
        flush_pc     = 16'h5678;
        consume      = 1'b1;
        consume_size = 4'd1;
        repeat (3) @(negedge clk);
        n_vec++; if (q_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", q_count); end
        n_vec++; if (q_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", q_data); end
        n_vec++; if (q_pc !== 16'h0000) begin n_err++; $display("FAIL reset_qpc: got %h want 0000", q_pc); end
        n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", fetch_req); end
        reset_n      = 1'b1;
        flush        = 1'b0;
        consume      = 1'b0;
        consume_size = 4'd0;
        m_bytes.delete();
        m_ps   = 16'hFFFF;
        m_fpc  = 16'h0000;
        m_qpc  = 16'h0000;
        m_disc = 1'b0;
        m_old  = 20'h00000;
    endtask

    task automatic test_fill();
        bit ok;
        logic [15:0] words [3] = '{16'h1100, 16'h3322, 16'h5544};
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL fill_req_timeout: got none want request %0d", k); end
            n_vec++;
            if (fetch_addr !== 20'hFFFF0 + 20'(2*k)) begin
                n_err++; $display("FAIL fill_addr: got %h want %h", fetch_addr, 20'hFFFF0 + 20'(2*k));
            end
            do_step(1'b1, words[k], 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
            n_vec++; if (q_count !== 4'(2*k+2)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", q_count, 2*k+2); end
            n_vec++; if (q_data !== exp_win()) begin n_err++; $display("FAIL fill_data: got %h want %h", q_data, exp_win()); end
        end
        repeat (3) idle_step();
        n_vec++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b want 0", fetch_req); end
        n_vec++; if (q_data !== 48'h554433221100) begin n_err++; $display("FAIL full_data: got %h want 554433221100", q_data); end
        n_vec++; if (q_pc !== 16'h0000) begin n_err++; $display("FAIL full_qpc: got %h want 0000", q_pc); end
    endtask

    task automatic test_consume_ack();
        bit ok;
        do_step(1'b0, 16'h0000, 1'b1, 4'd3, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_count !== 4'd3) begin n_err++; $display("FAIL cons3_count: got %0d want 3", q_count); end
        n_vec++; if (q_data !== 48'h000000554433) begin n_err++; $display("FAIL cons3_data: got %h want 000000554433", q_data); end
        n_vec++; if (q_pc !== 16'h0003) begin n_err++; $display("FAIL cons3_qpc: got %h want 0003", q_pc); end
        wait_req(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL cons_req_timeout: got none want request"); end
        n_vec++; if (fetch_addr !== 20'hFFFF6) begin n_err++; $display("FAIL cons_addr: got %h want FFFF6", fetch_addr); end
        do_step(1'b1, 16'hBBAA, 1'b1, 4'd1, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_count !== 4'd4) begin n_err++; $display("FAIL cons_ack_count: got %0d want 4", q_count); end
        n_vec++; if (q_data[23:16] !== 8'hAA) begin n_err++; $display("FAIL cons_ack_b2: got %h want AA", q_data[23:16]); end
        n_vec++; if (q_data[31:24] !== 8'hBB) begin n_err++; $display("FAIL cons_ack_b3: got %h want BB", q_data[31:24]); end
        n_vec++; if (q_pc !== 16'h0004) begin n_err++; $display("FAIL cons_ack_qpc: got %h want 0004", q_pc); end
    endtask

    task automatic test_flush_discard();
        bit ok;
        wait_req(ok);
        n_vec++; if (fetch_addr !== 20'hFFFF8) begin n_err++; $display("FAIL disc_pre_addr: got %h want FFFF8", fetch_addr); end
        do_step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0ABC, 16'h1234);
        n_vec++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL disc_req_held: got %b want 1", fetch_req); end
        n_vec++; if (q_pc !== 16'h1234) begin n_err++; $display("FAIL disc_qpc: got %h want 1234", q_pc); end
        idle_step();
        do_step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h1000, 16'h0003);
        idle_step();
        n_vec++; if (fetch_addr !== 20'hFFFF8) begin n_err++; $display("FAIL disc_addr_held: got %h want FFFF8", fetch_addr); end
        n_vec++; if (q_count !== 4'd0) begin n_err++; $display("FAIL disc_count: got %0d want 0", q_count); end
        do_step(1'b1, 16'hDEAD, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_count !== 4'd0) begin n_err++; $display("FAIL disc_dropped: got %0d want 0", q_count); end
        wait_req(ok);
        n_vec++; if (fetch_addr !== 20'h10003) begin n_err++; $display("FAIL odd_addr: got %h want 10003", fetch_addr); end
        do_step(1'b1, 16'h55AA, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_count !== 4'd1) begin n_err++; $display("FAIL odd_count: got %0d want 1", q_count); end
        n_vec++; if (q_data !== 48'h000000000055) begin n_err++; $display("FAIL odd_data: got %h want 000000000055", q_data); end
        wait_req(ok);
        n_vec++; if (fetch_addr !== 20'h10004) begin n_err++; $display("FAIL odd_next_addr: got %h want 10004", fetch_addr); end
    endtask

    task automatic test_seg_wrap();
        bit ok;
        do_step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h2000, 16'hFFFE);
        wait_req(ok);
        if (m_disc) begin
            do_step(1'b1, 16'hBEEF, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
            wait_req(ok);
        end
        n_vec++; if (fetch_addr !== 20'h2FFFE) begin n_err++; $display("FAIL wrap_addr0: got %h want 2FFFE", fetch_addr); end
        do_step(1'b1, 16'h2211, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
        wait_req(ok);
        n_vec++; if (fetch_addr !== 20'h20000) begin n_err++; $display("FAIL wrap_addr1: got %h want 20000", fetch_addr); end
        do_step(1'b1, 16'h4433, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_qpc0: got %h want FFFE", q_pc); end
        do_step(1'b0, 16'h0000, 1'b1, 4'd1, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_qpc1: got %h want FFFF", q_pc); end
        do_step(1'b0, 16'h0000, 1'b1, 4'd1, 1'b0, 16'h0000, 16'h0000);
        n_vec++; if (q_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_qpc2: got %h want 0000", q_pc); end
        n_vec++; if (q_data[7:0] !== 8'h33) begin n_err++; $display("FAIL wrap_head: got %h want 33", q_data[7:0]); end
    endtask

`ifdef PREFETCH_BYPASS_EN
    task automatic test_bypass();
        bit ok;
        do_step(1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0100);
        wait_req(ok);
        if (m_disc) begin
            do_step(1'b1, 16'hBEEF, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
            wait_req(ok);
        end
        n_vec++; if (fetch_addr !== 20'h00100) begin n_err++; $display("FAIL byp_addr: got %h want 00100", fetch_addr); end
        fetch_ack  = 1'b1;
        fetch_data = 16'h3412;
        #1;
        n_vec++; if (q_count !== 4'd2) begin n_err++; $display("FAIL byp_count: got %0d want 2", q_count); end
        n_vec++; if (q_data[15:0] !== 16'h3412) begin n_err++; $display("FAIL byp_data: got %h want 3412", q_data[15:0]); end
        consume      = 1'b1;
        consume_size = 4'd2;
        tick();
        m_fpc = m_fpc + 16'd2;
        m_qpc = m_qpc + 16'd2;
        n_vec++; if (q_count !== 4'd0) begin n_err++; $display("FAIL byp_after: got %0d want 0", q_count); end
        n_vec++; if (q_pc !== 16'h0102) begin n_err++; $display("FAIL byp_qpc: got %h want 0102", q_pc); end
    endtask
`endif

    task automatic test_random();
        bit          a, c, f;
        logic [3:0]  cs;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_vec++;
            if (q_count !== 4'(m_bytes.size())) begin
                n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, q_count, m_bytes.size());
            end
            n_vec++;
            if (q_data !== exp_win()) begin
                n_err++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, q_data, exp_win());
            end
            n_vec++;
            if (q_pc !== m_qpc) begin
                n_err++; $display("FAIL rnd_qpc@%0d: got %h want %h", cyc, q_pc, m_qpc);
            end
            if (fetch_req === 1'b1) begin
                n_vec++;
                if (fetch_addr !== m_req_addr()) begin
                    n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, fetch_addr, m_req_addr());
                end
            end
            a  = (fetch_req === 1'b1) && ($urandom_range(0, 2) != 0);
            c  = (m_bytes.size() > 0) && ($urandom_range(0, 2) == 0);
            cs = c ? 4'($urandom_range(1, m_bytes.size())) : 4'd0;
            f  = ($urandom_range(0, 39) == 0);
            do_step(a, 16'($urandom), c, cs, f, 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_fill();
        test_consume_ack();
        test_flush_discard();
        test_seg_wrap();
`ifdef PREFETCH_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
